// File: rtl/rr_grant_sequencer.sv
// -----------------------------------------------------------------------------
// rr_grant_sequencer
//
// Purpose
//   Round-robin arbiter sharing one resource among four requesters. The
//   winning index is registered and expanded into a one-hot grant that can
//   drive board LEDs directly. An owner keeps the grant while it continues to
//   request, up to an optional hold limit. Every release is followed by one
//   idle cycle (break-before-make) before the next owner is granted.
//
// Parameters
//   MAX_HOLD   maximum consecutive grant cycles per owner; 0 = unlimited
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous reset, active-low
//   req        in   4  level request per requester, held until served
//   gnt        out  4  one-hot grant, 4'b0000 when no owner
//   gnt_idx    out  2  index of current owner (holds last value when idle)
//   gnt_valid  out  1  high while a requester owns the resource
//   timeout    out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
// -----------------------------------------------------------------------------
module rr_grant_sequencer #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // Hold counter sizing. MAX_HOLD=0 would give a zero-width counter, so the
    // width is clamped to one bit in that case.
    localparam int unsigned CNT_W_RAW = $clog2(MAX_HOLD + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST    = HOLD_LIMITED ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_SAT      = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e           state_q,     state_d;
    logic [1:0]       ptr_q,       ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [3:0]       gnt_q,       gnt_d;
    logic [1:0]       gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] decode_onehot(input logic [1:0] idx);
        decode_onehot = 4'b0001 << idx;
    endfunction

    // -------------------------------------------------------------------------
    // Rotating priority scan: start at ptr_q, ascend, wrap 3 -> 0.
    // The loop runs from the farthest offset down to offset 0 so that the
    // candidate closest to the pointer is the last one written and wins.
    // -------------------------------------------------------------------------
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int off = 3; off >= 0; off--) begin
            cand = ptr_q + off[1:0];
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Forced release fires on the owner's MAX_HOLD-th grant cycle.
    logic limit_hit;
    assign limit_hit = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_GAP: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    gnt_idx_d   = win_idx;
                    gnt_d       = decode_onehot(win_idx);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                // A dropped request takes precedence over the hold limit, so
                // a tie is a normal release without a timeout pulse.
                if (!req[gnt_idx_q] || limit_hit) begin
                    state_d     = ST_GAP;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 2'd1;
                    timeout_d   = req[gnt_idx_q];
                end else if (hold_cnt_q != CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and ignores req entirely, so an unknown
        // request pattern while rst_n is low cannot leak into the state.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 4'b0000;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the same pre-edge values, independent of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
